golomb_param_scheduler: RTL and testbench

Adaptive parameter controller for the Golomb coding stage. It takes the stream of mapped (non-negative) residuals and keeps a running accumulator and sample counter per block. For every sample it emits the value on one AXI-Stream channel and the Golomb parameter k on a second channel, so the coder's value and parameter inputs always stay paired. It resets its statistics at every block boundary (input_last).

---
 rtl/golomb_param_scheduler.sv | 101 ++++++++++
 tb/tb_golomb_param_scheduler.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/golomb_param_scheduler.sv
// Adaptive Golomb parameter controller: tracks per-block accumulator A and count N,
// and emits each residual paired with its k on two independent AXI-Stream channels.
module golomb_param_scheduler #(
  parameter int DATA_WIDTH          = 19,
  parameter int MAX_PARAM_VALUE     = 19,
  parameter int MAX_PARAM_VALUE_LOG = 5,
  parameter int COUNT_WIDTH         = 7,
  parameter int COUNT_THRESHOLD     = 64,
  parameter int ACC_WIDTH           = 26,
  parameter int INIT_ACC            = 4,
  parameter int INIT_COUNT          = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [DATA_WIDTH-1:0]          input_data,
  input  logic                           input_last,
  input  logic                           input_valid,
  output logic                           input_ready,
  output logic [DATA_WIDTH-1:0]          output_value_data,
  output logic                           output_value_last,
  output logic                           output_value_valid,
  input  logic                           output_value_ready,
  output logic [MAX_PARAM_VALUE_LOG-1:0] output_param_data,
  output logic                           output_param_valid,
  input  logic                           output_param_ready
);

  // Wide enough that N << MAX_PARAM_VALUE never loses bits against A.
  localparam int CMP_WIDTH = ACC_WIDTH + MAX_PARAM_VALUE;

  logic [ACC_WIDTH-1:0]           acc;
  logic [COUNT_WIDTH-1:0]         cnt;
  logic [ACC_WIDTH-1:0]           acc_sum;
  logic [COUNT_WIDTH-1:0]         cnt_inc;
  logic [CMP_WIDTH-1:0]           acc_ext;
  logic [CMP_WIDTH-1:0]           cnt_ext;
  logic [MAX_PARAM_VALUE_LOG-1:0] k;
  logic                           val_pend;
  logic                           par_pend;
  logic                           capture;

  // NOTE: k defaults to the saturated value before the loop so every path assigns it;
  // a combinational block missing a default on some path would infer a latch.
  always_comb begin
    acc_ext = CMP_WIDTH'(acc);
    cnt_ext = CMP_WIDTH'(cnt);
    k       = MAX_PARAM_VALUE_LOG'(MAX_PARAM_VALUE);
    // Scanning downward leaves the smallest qualifying shift in k.
    for (int i = MAX_PARAM_VALUE; i >= 0; i--) begin
      if ((cnt_ext << i) >= acc_ext) k = MAX_PARAM_VALUE_LOG'(i);
    end
  end

  // Ready when every pending beat either is absent or completes this cycle.
  assign input_ready = (!val_pend || output_value_ready) &&
                       (!par_pend || output_param_ready);
  assign capture     = input_valid && input_ready;

  assign acc_sum = acc + ACC_WIDTH'(input_data);
  assign cnt_inc = cnt + COUNT_WIDTH'(1);

  assign output_value_valid = val_pend;
  assign output_param_valid = par_pend;

  // NOTE: all state uses non-blocking assignments so every register samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc               <= ACC_WIDTH'(INIT_ACC);
      cnt               <= COUNT_WIDTH'(INIT_COUNT);
      val_pend          <= 1'b0;
      par_pend          <= 1'b0;
      output_value_data <= '0;
      output_value_last <= 1'b0;
      output_param_data <= '0;
    end else begin
      if (capture) begin
        output_value_data <= input_data;
        output_value_last <= input_last;
        output_param_data <= k;
        // A capture always refills both slots, overriding any completion.
        val_pend          <= 1'b1;
        par_pend          <= 1'b1;
        if (input_last) begin
          acc <= ACC_WIDTH'(INIT_ACC);
          cnt <= COUNT_WIDTH'(INIT_COUNT);
        end else if (cnt_inc == COUNT_WIDTH'(COUNT_THRESHOLD)) begin
          acc <= acc_sum >> 1;
          cnt <= cnt_inc >> 1;
        end else begin
          acc <= acc_sum;
          cnt <= cnt_inc;
        end
      end else begin
        if (output_value_ready) val_pend <= 1'b0;
        if (output_param_ready) par_pend <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_golomb_param_scheduler.sv
// Directed bench for golomb_param_scheduler: expected k values are hand-derived
// from the smallest-k rule with defaults A=4, N=1.
module tb_golomb_param_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic [18:0] input_data;
  logic        input_last;
  logic        input_valid;
  logic        input_ready;
  logic [18:0] output_value_data;
  logic        output_value_last;
  logic        output_value_valid;
  logic        output_value_ready;
  logic [4:0]  output_param_data;
  logic        output_param_valid;
  logic        output_param_ready;

  int checks = 0;
  int errors = 0;

  golomb_param_scheduler dut (
    .clk                (clk),
    .rst                (rst),
    .input_data         (input_data),
    .input_last         (input_last),
    .input_valid        (input_valid),
    .input_ready        (input_ready),
    .output_value_data  (output_value_data),
    .output_value_last  (output_value_last),
    .output_value_valid (output_value_valid),
    .output_value_ready (output_value_ready),
    .output_param_data  (output_param_data),
    .output_param_valid (output_param_valid),
    .output_param_ready (output_param_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; input_valid = 1'b0; input_data = '0; input_last = 1'b0;
    output_value_ready = 1'b1; output_param_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // One capture with both readies high; outputs are checked one edge later.
  task automatic beat(input string tag, input logic [18:0] d, input bit l, input logic [4:0] exp_k);
    @(negedge clk);
    input_data = d; input_last = l; input_valid = 1'b1;
    check({tag, " in_ready"}, 32'(input_ready), 1);
    @(posedge clk); #1;
    input_valid = 1'b0;
    check({tag, " val_valid"}, 32'(output_value_valid), 1);
    check({tag, " par_valid"}, 32'(output_param_valid), 1);
    check({tag, " value"},     32'(output_value_data), 32'(d));
    check({tag, " last"},      32'(output_value_last), 32'(l));
    check({tag, " param"},     32'(output_param_data), 32'(exp_k));
  endtask

  initial begin
    rst = 1'b1; input_valid = 1'b0; input_data = '0; input_last = 1'b0;
    output_value_ready = 1'b1; output_param_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset val_valid", 32'(output_value_valid), 0);
    check("reset par_valid", 32'(output_param_valid), 0);
    check("reset value",     32'(output_value_data), 0);
    check("reset last",      32'(output_value_last), 0);
    check("reset param",     32'(output_param_data), 0);
    check("reset in_ready",  32'(input_ready), 1);

    // Cold start, back-to-back at one sample per cycle.
    beat("cold0", 19'd0, 1'b0, 5'd2);
    beat("cold1", 19'd0, 1'b0, 5'd1);

    // Growth and saturation.
    do_reset();
    beat("grow0", 19'd10, 1'b0, 5'd2);
    beat("grow1", 19'd3,  1'b0, 5'd3);
    do_reset();
    beat("sat0", 19'd524287, 1'b0, 5'd2);
    beat("sat1", 19'd0,      1'b0, 5'd19);

    // Halving: 63 zeros (A stays 4, N walks 1..63), then N=64 halves to 32, A to 2.
    do_reset();
    for (int n = 1; n <= 63; n++)
      beat($sformatf("halve%0d", n), 19'd0, 1'b0, (n == 1) ? 5'd2 : (n < 4) ? 5'd1 : 5'd0);
    beat("halve64", 19'd1000, 1'b0, 5'd0);
    // Halved: A=1002, N=33 -> k=5; without halving it would be A=1004, N=65 -> k=4.
    beat("halve65", 19'd0, 1'b0, 5'd5);

    // Block boundary.
    do_reset();
    beat("blk0", 19'd10, 1'b0, 5'd2);
    beat("blk1", 19'd3,  1'b0, 5'd3);
    beat("blk2", 19'd9,  1'b1, 5'd3);
    beat("blk3", 19'd0,  1'b0, 5'd2);

    // Independent backpressure on the parameter channel.
    do_reset();
    @(negedge clk);
    output_param_ready = 1'b0;
    input_data = 19'd5; input_last = 1'b0; input_valid = 1'b1;
    @(posedge clk); #1;
    input_data = 19'd7;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check($sformatf("bp%0d in_ready", c),  32'(input_ready), 0);
      check($sformatf("bp%0d par_valid", c), 32'(output_param_valid), 1);
      check($sformatf("bp%0d param", c),     32'(output_param_data), 2);
      check($sformatf("bp%0d val_valid", c), 32'(output_value_valid), (c == 0) ? 1 : 0);
      check($sformatf("bp%0d value", c),     32'(output_value_data), 5);
    end
    @(negedge clk);
    output_param_ready = 1'b1;
    #1;
    check("bp release in_ready", 32'(input_ready), 1);
    @(posedge clk); #1;
    input_valid = 1'b0;
    check("bp next val_valid", 32'(output_value_valid), 1);
    check("bp next par_valid", 32'(output_param_valid), 1);
    check("bp next value",     32'(output_value_data), 7);
    check("bp next param",     32'(output_param_data), 3);

    // Reset while both flags are pending.
    do_reset();
    beat("mid0", 19'd10, 1'b0, 5'd2);
    @(negedge clk);
    output_value_ready = 1'b0; output_param_ready = 1'b0;
    input_data = 19'd3; input_valid = 1'b1;
    @(posedge clk); #1;
    input_valid = 1'b0;
    check("mid pend val_valid", 32'(output_value_valid), 1);
    check("mid pend par_valid", 32'(output_param_valid), 1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid rst val_valid", 32'(output_value_valid), 0);
    check("mid rst par_valid", 32'(output_param_valid), 0);
    check("mid rst in_ready",  32'(input_ready), 1);
    output_value_ready = 1'b1; output_param_ready = 1'b1;
    beat("mid after", 19'd0, 1'b0, 5'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
